// File: rtl/omsp_defer_pkg.sv
// Shared definitions for the IRQ deferral scheduler: FSM encoding and the
// default deferral bound derived from the atomicity-monitor windows.
package omsp_defer_pkg;

  localparam int ATOM_BOUND           = 12;
  localparam int SM_ENTRY_ATOM_PERIOD = 12;
  localparam int DEFER_MAX_DFLT       = ATOM_BOUND + SM_ENTRY_ATOM_PERIOD + 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEFER = 2'd1,
    ST_GRANT = 2'd2
  } defer_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/omsp_irq_prio_enc.sv
// Fixed-priority encoder: the highest asserted index wins.
module omsp_irq_prio_enc #(
  parameter int NIRQ  = 14,
  parameter int IDX_W = 4
) (
  input  logic [NIRQ-1:0]  irq_vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Later (higher) indices overwrite earlier ones, giving highest-first priority.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/omsp_irq_defer_scheduler.sv
// Latches IRQs while gie is held low, grants the highest pending one when gie
// returns, and tracks per-request deferral latency with a sticky overrun flag.
module omsp_irq_defer_scheduler
  import omsp_defer_pkg::*;
#(
  parameter int NIRQ      = 14,
  parameter int DEFER_MAX = DEFER_MAX_DFLT,
  parameter int CNT_W     = $clog2(DEFER_MAX) + 1
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic [NIRQ-1:0]  irq_in,
  input  logic             gie,
  input  logic             irq_ack,
  input  logic             ovr_clr,
  output logic [NIRQ-1:0]  irq_req,
  output logic             irq_detect,
  output logic [NIRQ-1:0]  irq_pending,
  output logic [CNT_W-1:0] defer_cnt,
  output logic [CNT_W-1:0] defer_max_seen,
  output logic             defer_overrun
);

  localparam int IDX_W = idx_width(NIRQ);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_OVR = CNT_W'(DEFER_MAX - 1);

  defer_state_e     state_reg, state_next;
  logic [NIRQ-1:0]  pending_reg, pending_next;
  logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0] max_reg, max_next;
  logic             ovr_reg, ovr_next;
  logic             detect_reg, detect_next;
  logic [NIRQ-1:0]  ack_clear;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;

  omsp_irq_prio_enc #(.NIRQ(NIRQ), .IDX_W(IDX_W)) u_prio_enc (
    .irq_vec (pending_reg),
    .idx     (enc_idx),
    .valid   (enc_valid)
  );

  always_comb begin
    ack_clear      = '0;
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    cnt_inc        = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
    cnt_next       = cnt_reg;
    max_next       = max_reg;
    detect_next    = 1'b0;

    if (state_reg == ST_GRANT && irq_ack) begin
      ack_clear = NIRQ'(1) << grant_idx_reg;
    end
    // A line re-asserted in the ack cycle stays pending (set beats clear).
    pending_next = (pending_reg & ~ack_clear) | irq_in;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (enc_valid) begin
          if (gie) begin
            state_next     = ST_GRANT;
            grant_idx_next = enc_idx;
          end else begin
            state_next = ST_DEFER;
          end
        end
      end
      ST_DEFER: begin
        cnt_next = cnt_inc;
        if (gie) begin
          if (enc_valid) begin
            state_next     = ST_GRANT;
            grant_idx_next = enc_idx;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GRANT: begin
        if (irq_ack) begin
          cnt_next    = '0;
          max_next    = (cnt_reg > max_reg) ? cnt_reg : max_reg;
          detect_next = 1'b1;
          state_next  = (|pending_next) ? ST_DEFER : ST_IDLE;
        end else begin
          cnt_next = cnt_inc;
          if (!gie) state_next = ST_DEFER;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_reg != ST_IDLE && cnt_reg == CNT_OVR) ovr_next = 1'b1;
    else if (ovr_clr)                               ovr_next = 1'b0;
    else                                            ovr_next = ovr_reg;
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= '0;
      grant_idx_reg <= '0;
      cnt_reg       <= '0;
      max_reg       <= '0;
      ovr_reg       <= 1'b0;
      detect_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      grant_idx_reg <= grant_idx_next;
      cnt_reg       <= cnt_next;
      max_reg       <= max_next;
      ovr_reg       <= ovr_next;
      detect_reg    <= detect_next;
    end
  end

  // Request is decoded from registered state only, so reset drops it at once.
  assign irq_req        = (state_reg == ST_GRANT) ? (NIRQ'(1) << grant_idx_reg) : '0;
  assign irq_detect     = detect_reg;
  assign irq_pending    = pending_reg;
  assign defer_cnt      = cnt_reg;
  assign defer_max_seen = max_reg;
  assign defer_overrun  = ovr_reg;

endmodule
